dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter that shares the single-port data memory between the CPU data path (port CPU) and a memory loader/DMA engine (port LD). The CPU sees a stall signal while it waits. The loader sees a grant plus registered read data. The arbiter sits between the CPU's load/store signals and the data memory, and drives the memory's address, write data and read/write strobes. Memory read data is combinational in the same cycle; memory writes commit on the clock edge.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_BURST, 4, consecutive loader grants allowed before priority returns to the CPU (≥1)

- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-low reset
- cpu_req_i  in  1  CPU memory access request (load or store)
- cpu_we_i  in  1  1 = store, 0 = load
- cpu_addr_i  in  ADDR_W  CPU address
- cpu_wdata_i  in  DATA_W  CPU store data
- cpu_stall_o  out  1  CPU request not served this cycle; CPU must hold PC and request
- cpu_rdata_o  out  DATA_W  combinational pass-through of mem_rdata_i
- ld_req_i  in  1  loader request
- ld_we_i  in  1  1 = write, 0 = read
- ld_addr_i  in  ADDR_W  loader address
- ld_wdata_i  in  DATA_W  loader write data
- ld_gnt_o  out  1  loader access performed this cycle
- ld_rdata_o  out  DATA_W  registered loader read data
- ld_rvalid_o  out  1  ld_rdata_o valid, one cycle after a granted loader read
- mem_addr_o  out  ADDR_W  to data memory
- mem_wdata_o  out  DATA_W  to data memory
- mem_read_o  out  1  to data memory
- mem_write_o  out  1  to data memory
- mem_rdata_i  in  DATA_W  from data memory
- stall_cnt_o  out  16  saturating count of cycles with cpu_stall_o=1

## Operation
State registers:
- pri: priority owner, CPU or LD
- cnt: loader burst count, 0..MAX_BURST-1
- ld_rdata_o, ld_rvalid_o, stall_cnt_o

Combinational grant (work-conserving):
- g_ld = ld_req_i & (pri==LD | ~cpu_req_i)
- g_cpu = cpu_req_i & ~g_ld
- ld_gnt_o = g_ld
- cpu_stall_o = cpu_req_i & ~g_cpu
- Memory port is driven from the granted requester:
  - mem_addr_o, mem_wdata_o = that port's address and data
  - mem_write_o = its we
  - mem_read_o = ~we
- No grant: mem_addr_o=0, mem_wdata_o=0, both strobes 0.
- An ungranted port never reaches memory; a stalled CPU store must not write.
- cpu_rdata_o = mem_rdata_i at all times. The CPU uses it only when a load is granted.

Priority update at each rising edge:
- g_cpu: pri←LD, cnt←0.
- g_ld and cnt==MAX_BURST-1: pri←CPU, cnt←0.
- g_ld otherwise: cnt←cnt+1; pri unchanged.
- No grant: pri and cnt hold.
- Net effect under continuous contention: 1 CPU access, then MAX_BURST loader accesses, repeating.

Loader read return:
- ld_rvalid_o ← g_ld & ~ld_we_i
- ld_rdata_o ← mem_rdata_i when g_ld & ~ld_we_i; otherwise it holds.

Stall counter: stall_cnt_o increments on each edge where cpu_stall_o=1 and saturates at 0xFFFF (no wrap).

## Timing
- Reset (rst_i=0), asynchronous:
  - pri=CPU, cnt=0, ld_rvalid_o=0, ld_rdata_o=0, stall_cnt_o=0
  - While rst_i=0, g_cpu and g_ld are forced to 0, and cpu_stall_o=0, ld_gnt_o=0, mem_read_o=0, mem_write_o=0, mem_addr_o=0, mem_wdata_o=0.
  - A reset mid-burst discards pri and cnt.
- CPU path: zero-latency grant; a granted load returns data in the same cycle; a granted store commits at that cycle's edge.
- Loader path: grant in cycle n; write commits at the edge ending n; read data is on ld_rdata_o with ld_rvalid_o=1 in cycle n+1.
- Loader handshake: the loader holds its request fields stable until it sees ld_gnt_o=1, then advances on the next cycle. The CPU holds its fields while cpu_stall_o=1.
- Simultaneous requests with pri=CPU: CPU wins. With pri=LD: LD wins.
- MAX_BURST=1: strict alternation under contention.

## Test plan
- CPU only:
  - Stimulus: load addr 0x10, mem_rdata_i=0xDEADBEEF.
  - Response: cpu_stall_o=0, cpu_rdata_o=0xDEADBEEF, mem_read_o=1, mem_addr_o=0x10, ld_gnt_o=0, same cycle.
- Loader only, four writes:
  - Stimulus: addrs 0x0/0x4/0x8/0xC, data 1/2/3/4, back to back.
  - Response: ld_gnt_o=1 each cycle, mem_write_o=1 with matching addr/data, ld_rvalid_o=0; pri=CPU after the 4th.
- Continuous contention from reset, MAX_BURST=4:
  - Cycle 0: CPU granted.
  - Cycles 1-4: LD granted, cpu_stall_o=1.
  - Cycle 5: CPU granted.
  - Cycles 6-9: LD granted, cpu_stall_o=1.
  - stall_cnt_o=8 after cycle 9; no stalled CPU store reaches mem_write_o.
- Loader read:
  - Stimulus: addr 0x20 granted in cycle n, mem_rdata_i=0x00001234.
  - Response in cycle n+1: ld_rvalid_o=1, ld_rdata_o=0x00001234. A subsequent granted write gives ld_rvalid_o=0 while ld_rdata_o holds.
- Reset mid-burst:
  - Stimulus: rst_i=0 after 2 loader grants under contention.
  - Response: all grants and strobes 0 immediately. After release with both requesting, CPU is granted first, then 4 loader grants.
- Stall saturation:
  - Stimulus: hold CPU stalled for 70000 cycles (loader requesting, pri forced LD via repeated bursts with CPU idle not applicable; use MAX_BURST large or check by count).
  - Response: stall_cnt_o reaches 0xFFFF and holds without wrapping.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Shares one single-port data memory between the CPU data path and a loader/DMA port.
// The CPU gets one access, then the loader gets up to MAX_BURST back-to-back accesses, repeating.
module dmem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic              cpu_stall_o,
  output logic [DATA_W-1:0] cpu_rdata_o,
  input  logic              ld_req_i,
  input  logic              ld_we_i,
  input  logic [ADDR_W-1:0] ld_addr_i,
  input  logic [DATA_W-1:0] ld_wdata_i,
  output logic              ld_gnt_o,
  output logic [DATA_W-1:0] ld_rdata_o,
  output logic              ld_rvalid_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [15:0]       stall_cnt_o
);

  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  typedef enum logic {
    PRI_CPU = 1'b0,
    PRI_LD  = 1'b1
  } pri_t;

  pri_t             pri_r;
  logic [CNT_W-1:0] cnt_r;
  logic             g_ld_s;
  logic             g_cpu_s;

  // Grants are gated by reset so nothing reaches memory while rst_i is low.
  assign g_ld_s      = rst_i & ld_req_i & ((pri_r == PRI_LD) | ~cpu_req_i);
  assign g_cpu_s     = rst_i & cpu_req_i & ~g_ld_s;
  assign ld_gnt_o    = g_ld_s;
  assign cpu_stall_o = rst_i & cpu_req_i & ~g_cpu_s;
  assign cpu_rdata_o = mem_rdata_i;

  // Steer the memory port from whichever requester holds the grant.
  always_comb begin
    mem_addr_o  = {ADDR_W{1'b0}};
    mem_wdata_o = {DATA_W{1'b0}};
    mem_read_o  = 1'b0;
    mem_write_o = 1'b0;
    if (g_cpu_s) begin
      mem_addr_o  = cpu_addr_i;
      mem_wdata_o = cpu_wdata_i;
      mem_read_o  = ~cpu_we_i;
      mem_write_o = cpu_we_i;
    end else if (g_ld_s) begin
      mem_addr_o  = ld_addr_i;
      mem_wdata_o = ld_wdata_i;
      mem_read_o  = ~ld_we_i;
      mem_write_o = ld_we_i;
    end else begin
      mem_addr_o  = {ADDR_W{1'b0}};
      mem_wdata_o = {DATA_W{1'b0}};
    end
  end

  // Priority owner and loader burst counter.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pri_r <= PRI_CPU;
      cnt_r <= {CNT_W{1'b0}};
    end else if (g_cpu_s) begin
      pri_r <= PRI_LD;
      cnt_r <= {CNT_W{1'b0}};
    end else if (g_ld_s) begin
      if (cnt_r == CNT_LAST) begin
        pri_r <= PRI_CPU;
        cnt_r <= {CNT_W{1'b0}};
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end else begin
      pri_r <= pri_r;
      cnt_r <= cnt_r;
    end
  end

  // Loader read data is captured one cycle after its granted read.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ld_rvalid_o <= 1'b0;
      ld_rdata_o  <= {DATA_W{1'b0}};
    end else begin
      ld_rvalid_o <= g_ld_s & ~ld_we_i;
      if (g_ld_s && !ld_we_i) begin
        ld_rdata_o <= mem_rdata_i;
      end else begin
        ld_rdata_o <= ld_rdata_o;
      end
    end
  end

  // Saturating count of CPU stall cycles.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_o <= 16'h0000;
    end else if (cpu_stall_o && (stall_cnt_o != 16'hFFFF)) begin
      stall_cnt_o <= stall_cnt_o + 16'h0001;
    end else begin
      stall_cnt_o <= stall_cnt_o;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: reset, CPU/loader paths, contention, mid-burst reset and stall
// counter saturation (the latter on a second instance with a very long loader burst).
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [31:0] cpu_addr = 32'h0, cpu_wdata = 32'h0;
  logic        cpu_stall;
  logic [31:0] cpu_rdata;
  logic        ld_req = 1'b0, ld_we = 1'b0;
  logic [31:0] ld_addr = 32'h0, ld_wdata = 32'h0;
  logic        ld_gnt;
  logic [31:0] ld_rdata;
  logic        ld_rvalid;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_rdata = 32'h0;
  logic [15:0] stall_cnt;

  logic        s_rst_n = 1'b0;
  logic        s_stall, s_gnt, s_rvalid, s_read, s_write;
  logic [31:0] s_cpu_rdata, s_ld_rdata, s_addr, s_wdata;
  logic [15:0] s_stall_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(4)) dut (
    .clk_i(clk), .rst_i(rst_n),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_stall_o(cpu_stall), .cpu_rdata_o(cpu_rdata),
    .ld_req_i(ld_req), .ld_we_i(ld_we), .ld_addr_i(ld_addr), .ld_wdata_i(ld_wdata),
    .ld_gnt_o(ld_gnt), .ld_rdata_o(ld_rdata), .ld_rvalid_o(ld_rvalid),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_read_o(mem_read),
    .mem_write_o(mem_write), .mem_rdata_i(mem_rdata), .stall_cnt_o(stall_cnt)
  );

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(100000)) u_sat (
    .clk_i(clk), .rst_i(s_rst_n),
    .cpu_req_i(1'b1), .cpu_we_i(1'b0), .cpu_addr_i(32'h0), .cpu_wdata_i(32'h0),
    .cpu_stall_o(s_stall), .cpu_rdata_o(s_cpu_rdata),
    .ld_req_i(1'b1), .ld_we_i(1'b1), .ld_addr_i(32'h4), .ld_wdata_i(32'h5),
    .ld_gnt_o(s_gnt), .ld_rdata_o(s_ld_rdata), .ld_rvalid_o(s_rvalid),
    .mem_addr_o(s_addr), .mem_wdata_o(s_wdata), .mem_read_o(s_read),
    .mem_write_o(s_write), .mem_rdata_i(32'h0), .stall_cnt_o(s_stall_cnt)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Both ports issue stores every cycle; bit c of cpu_mask marks cycles the CPU must win.
  task automatic run_pattern(input string tag, input int n, input logic [15:0] cpu_mask);
    logic [15:0] m;
    int          ld_idx;
    logic        cpu_turn;
    m = cpu_mask;
    ld_idx = 0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h100; cpu_wdata = 32'h0000C0C0;
    ld_req = 1'b1;  ld_we = 1'b1;
    for (int c = 0; c < n; c++) begin
      cpu_turn = m[c];
      ld_addr  = 32'h200 + 32'(ld_idx) * 32'd4;
      ld_wdata = 32'(ld_idx) + 32'd1;
      @(negedge clk);
      check_eq({tag, "_stall"}, 64'(cpu_stall), 64'(!cpu_turn));
      check_eq({tag, "_gnt"}, 64'(ld_gnt), 64'(!cpu_turn));
      check_eq({tag, "_wr"}, 64'(mem_write), 64'd1);
      check_eq({tag, "_addr"}, 64'(mem_addr), 64'(cpu_turn ? 32'h100 : ld_addr));
      check_eq({tag, "_wdata"}, 64'(mem_wdata), 64'(cpu_turn ? 32'h0000C0C0 : ld_wdata));
      if (!cpu_turn) ld_idx++;
      @(posedge clk); #1;
    end
    cpu_req = 1'b0; ld_req = 1'b0;
  endtask

  initial begin
    // Reset with both ports requesting: nothing may reach memory.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h100; ld_req = 1'b1; ld_we = 1'b1; ld_addr = 32'h200;
    @(negedge clk);
    check_eq("rst_stall", 64'(cpu_stall), 64'd0);
    check_eq("rst_gnt", 64'(ld_gnt), 64'd0);
    check_eq("rst_read", 64'(mem_read), 64'd0);
    check_eq("rst_write", 64'(mem_write), 64'd0);
    check_eq("rst_addr", 64'(mem_addr), 64'd0);
    check_eq("rst_rvalid", 64'(ld_rvalid), 64'd0);
    check_eq("rst_rdata", 64'(ld_rdata), 64'd0);
    check_eq("rst_scnt", 64'(stall_cnt), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Contention from reset: CPU, 4x LD, CPU, 4x LD.
    run_pattern("cont", 10, 16'h0021);

    // CPU-only load; pri is back to CPU after the 4th loader grant.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10; mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    check_eq("cont_scnt", 64'(stall_cnt), 64'd8);
    check_eq("cpu_stall", 64'(cpu_stall), 64'd0);
    check_eq("cpu_rdata", 64'(cpu_rdata), 64'hDEADBEEF);
    check_eq("cpu_read", 64'(mem_read), 64'd1);
    check_eq("cpu_write", 64'(mem_write), 64'd0);
    check_eq("cpu_addr", 64'(mem_addr), 64'h10);
    check_eq("cpu_gnt", 64'(ld_gnt), 64'd0);
    @(posedge clk); #1;
    cpu_req = 1'b0;

    // Loader-only back-to-back writes.
    for (int i = 0; i < 4; i++) begin
      ld_req = 1'b1; ld_we = 1'b1; ld_addr = 32'(i) * 32'd4; ld_wdata = 32'(i) + 32'd1;
      @(negedge clk);
      check_eq("ldw_gnt", 64'(ld_gnt), 64'd1);
      check_eq("ldw_write", 64'(mem_write), 64'd1);
      check_eq("ldw_read", 64'(mem_read), 64'd0);
      check_eq("ldw_addr", 64'(mem_addr), 64'(32'(i) * 32'd4));
      check_eq("ldw_wdata", 64'(mem_wdata), 64'(32'(i) + 32'd1));
      check_eq("ldw_rvalid", 64'(ld_rvalid), 64'd0);
      @(posedge clk); #1;
    end

    // After four loader grants the CPU owns priority again.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40; ld_we = 1'b0; ld_addr = 32'h44;
    @(negedge clk);
    check_eq("pri_cpu_stall", 64'(cpu_stall), 64'd0);
    check_eq("pri_cpu_gnt", 64'(ld_gnt), 64'd0);
    @(posedge clk); #1;
    cpu_req = 1'b0;

    // Loader read returns one cycle later; a following write holds the data.
    ld_req = 1'b1; ld_we = 1'b0; ld_addr = 32'h20; mem_rdata = 32'h00001234;
    @(negedge clk);
    check_eq("ldr_gnt", 64'(ld_gnt), 64'd1);
    check_eq("ldr_read", 64'(mem_read), 64'd1);
    check_eq("ldr_addr", 64'(mem_addr), 64'h20);
    @(posedge clk); #1;
    ld_we = 1'b1; ld_addr = 32'h24; ld_wdata = 32'h55; mem_rdata = 32'h00009999;
    @(negedge clk);
    check_eq("ldr_rvalid", 64'(ld_rvalid), 64'd1);
    check_eq("ldr_rdata", 64'(ld_rdata), 64'h1234);
    check_eq("ldr_wgnt", 64'(ld_gnt), 64'd1);
    @(posedge clk); #1;
    ld_req = 1'b0;
    @(negedge clk);
    check_eq("ldr_rvalid_wr", 64'(ld_rvalid), 64'd0);
    check_eq("ldr_rdata_hold", 64'(ld_rdata), 64'h1234);
    @(posedge clk); #1;

    // pri=LD, cnt=2 here: LD, LD, CPU, LD, LD; then reset mid-burst.
    run_pattern("mid", 5, 16'h0004);
    check_eq("mid_scnt", 64'(stall_cnt), 64'd12);
    cpu_req = 1'b1; ld_req = 1'b1;
    rst_n = 1'b0;
    #1;
    check_eq("mrst_stall", 64'(cpu_stall), 64'd0);
    check_eq("mrst_gnt", 64'(ld_gnt), 64'd0);
    check_eq("mrst_write", 64'(mem_write), 64'd0);
    check_eq("mrst_scnt", 64'(stall_cnt), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_pattern("post", 6, 16'h0021);

    // Stall counter saturation on the long-burst instance.
    @(posedge clk); #1;
    s_rst_n = 1'b1;
    repeat (100) @(posedge clk);
    @(negedge clk);
    check_eq("sat_early", 64'(s_stall_cnt), 64'd99);
    repeat (65435) @(posedge clk);
    @(negedge clk);
    check_eq("sat_fffe", 64'(s_stall_cnt), 64'hFFFE);
    check_eq("sat_stall", 64'(s_stall), 64'd1);
    @(posedge clk);
    @(negedge clk);
    check_eq("sat_ffff", 64'(s_stall_cnt), 64'hFFFF);
    repeat (300) @(posedge clk);
    @(negedge clk);
    check_eq("sat_hold", 64'(s_stall_cnt), 64'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
